act_with_mem: RTL and testbench
===============================

# act_with_mem

Parametrised, multi-mode successor to the single-function ReLU-with-memory block. On `start` it streams `CHANNELS*HEIGHT*WIDTH` signed elements from the shared `mem` through the tri-state `address_bus`/`data_bus`, applies a runtime-selected activation, and writes the results back starting at `output_addr`. It sits beside the conv/pool engines as a bus master on the same near-memory bus and signals completion with a sticky `done`.

## Interface
- DATA_WIDTH, 8: element width; signed two's complement.
- DATABUS_WIDTH, 32: memory word width; one element per word, held in the low DATA_WIDTH bits, sign-extended.
- ADDR_WIDTH, 8: memory address width.
- HEIGHT, 2 / WIDTH, 3 / CHANNELS, 1: tensor dimensions; N = CHANNELS*HEIGHT*WIDTH (≥1).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset (one clock; asynchronous active-low reset).
- start  in  1  begin a run; sampled only when idle.
- mode  in  2  0 identity, 1 ReLU, 2 leaky ReLU, 3 clamped ReLU.
- leak_shift  in  4  arithmetic right shift applied to negatives in mode 2.
- clamp_max  in  DATA_WIDTH  signed upper bound for mode 3.
- input_addr, output_addr  in  ADDR_WIDTH  base addresses.
- busy  out  1  high from the cycle after `start` is accepted until `done` rises.
- done  out  1  sticky completion flag; cleared when the next `start` is accepted.
- mem_sel, mem_w  out  1  memory select / write enable.
- address_bus  inout  ADDR_WIDTH  driven only while busy, else Z.
- data_bus  inout  DATABUS_WIDTH  driven only in WR, else Z.

## Operation
- `start`, `mode`, `leak_shift`, `clamp_max`, `input_addr`, and `output_addr` are latched on acceptance. Later changes have no effect on the run.
- FSM: IDLE → RD → CAP → WR → (RD for the next element | DONE) → IDLE.
  - IDLE: buses Z, mem_sel=0, mem_w=0.
  - RD: address_bus = input_addr+i, mem_sel=1, mem_w=0.
  - CAP: same drive as RD; data_bus[DATA_WIDTH-1:0] is captured at the rising edge ending CAP.
  - WR: address_bus = output_addr+i, data_bus = sign-extended result, mem_sel=1, mem_w=1.
  - DONE: one cycle; sets done=1 and clears busy.
- Address arithmetic is modulo 2^ADDR_WIDTH, so wrap-around is legal.
- In-place operation (input_addr == output_addr) is legal: each element is read before it is written.
- Activation (x signed, DATA_WIDTH bits):
  - Mode 0: y = x.
  - Mode 1: y = (x<0) ? 0 : x.
  - Mode 2: y = (x<0) ? x>>>leak_shift : x. A shift ≥ DATA_WIDTH yields -1 for any negative x.
  - Mode 3: y = (x<0) ? 0 : min(x, c), where c = max(clamp_max, 0).
- `start` while busy is ignored. `start` in IDLE while done=1 clears done and begins a new run.
- Element index i counts 0..N-1 in a $clog2(N+1)-bit counter.

## Timing
- Reset values: busy=0, done=0, mem_sel=0, mem_w=0, address_bus=Z, data_bus=Z, FSM=IDLE, i=0.
- Asserting rst mid-run releases the buses asynchronously, aborts the run, and leaves done=0. Partially written outputs remain in memory.
- Exactly 3 cycles per element.
- If `start` is sampled high at edge k:
  - RD of element 0 occupies cycle k..k+1.
  - The last WR ends at edge k+3N.
  - done and ~busy are visible after edge k+3N+1.
- Memory read contract: data is valid on data_bus by the end of the CAP cycle when sel=1 and w_en=0.
- Memory write contract: a write is committed at the rising edge ending WR.
- Bus ownership: the block never drives address_bus or data_bus outside busy. An external master may use the bus whenever busy=0.

## Configuration
- `ACT_LEAKY_EN` defined: mode 2 implements leaky ReLU with the barrel shifter.
- `ACT_LEAKY_EN` undefined: the shifter is omitted. `leak_shift` is ignored and mode 2 behaves identically to mode 1 (ReLU).
- All other modes are unaffected by the macro.

## Test plan
- The first five scenarios use input vector -3, -1, 0, 5, 127, -128 at addr 0, with output_addr=100.
- Mode 1 (ReLU) → mem[100..105] = 0, 0, 0, 5, 127, 0. done rises 3*6+1 cycles after start; busy is high in between.
- Mode 2, leak_shift=1, with `ACT_LEAKY_EN` → -2, -1, 0, 5, 127, -64. Same stimulus without the macro → ReLU result.
- Mode 3, clamp_max=6 → 0, 0, 0, 5, 6, 0. clamp_max=-4 → all 0.
- Mode 0 in place (output_addr=0) → mem[0..5] unchanged. A second `start` pulsed mid-run is ignored, and done rises once.
- rst driven low during element 3's WR → buses Z in the same cycle, done stays 0. A subsequent full run completes correctly.
- CHANNELS=2, input_addr=250, output_addr=120, 12 elements → reads wrap through 255→0, and 12 results are written at 120..131.

Source files
------------

// File: rtl/act_with_mem.sv
// Streams N signed elements from memory, applies a selectable activation, writes them back.
// Define ACT_LEAKY_EN to build the leaky-ReLU shifter; otherwise mode 2 acts as ReLU.
module act_with_mem #(
    parameter int DATA_WIDTH    = 8,
    parameter int DATABUS_WIDTH = 32,
    parameter int ADDR_WIDTH    = 8,
    parameter int HEIGHT        = 2,
    parameter int WIDTH         = 3,
    parameter int CHANNELS      = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [1:0]                   mode,
    input  logic [3:0]                   leak_shift,
    input  logic signed [DATA_WIDTH-1:0] clamp_max,
    input  logic [ADDR_WIDTH-1:0]        input_addr,
    input  logic [ADDR_WIDTH-1:0]        output_addr,
    output logic                         busy,
    output logic                         done,
    output logic                         mem_sel,
    output logic                         mem_w,
    inout  wire  [ADDR_WIDTH-1:0]        address_bus,
    inout  wire  [DATABUS_WIDTH-1:0]     data_bus
);

    localparam int N  = CHANNELS * HEIGHT * WIDTH;
    localparam int IW = $clog2(N + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_DONE
    } state_t;

    state_t                           r_state;
    logic [IW-1:0]                    r_idx;
    logic                             r_busy;
    logic                             r_done;
    logic                             r_sel;
    logic                             r_w;
    logic                             r_addr_oe;
    logic                             r_data_oe;
    logic [ADDR_WIDTH-1:0]            r_addr;
    logic signed [DATABUS_WIDTH-1:0]  r_wdata;
    logic [1:0]                       r_mode;
    logic signed [DATA_WIDTH-1:0]     r_clamp;
    logic [ADDR_WIDTH-1:0]            r_in_base;
    logic [ADDR_WIDTH-1:0]            r_out_base;

    logic signed [DATA_WIDTH-1:0]     w_x;
    logic signed [DATA_WIDTH-1:0]     w_y;
    logic signed [DATA_WIDTH-1:0]     w_relu;
    logic signed [DATA_WIDTH-1:0]     w_cmax;
    logic [IW-1:0]                    w_idx_nxt;
    logic                             w_last;
    logic                             w_unused_bus;

    assign w_x          = data_bus[DATA_WIDTH-1:0];
    assign w_unused_bus = ^data_bus;
    assign w_relu       = w_x[DATA_WIDTH-1] ? '0 : w_x;
    assign w_cmax       = r_clamp[DATA_WIDTH-1] ? '0 : r_clamp;
    assign w_idx_nxt    = r_idx + IW'(1);
    assign w_last       = (r_idx == IW'(N - 1));

`ifdef ACT_LEAKY_EN
    logic [3:0] r_shift;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_shift <= '0;
        else if (r_state == S_IDLE && start)
            r_shift <= leak_shift;
    end
`else
    logic w_unused_shift;
    assign w_unused_shift = ^leak_shift;
`endif

    always_comb begin
        w_y = w_x;
        case (r_mode)
            2'd0: w_y = w_x;
            2'd1: w_y = w_relu;
`ifdef ACT_LEAKY_EN
            // >>> on a signed value saturates to -1 for shifts >= DATA_WIDTH
            2'd2: w_y = w_x[DATA_WIDTH-1] ? (w_x >>> r_shift) : w_x;
`else
            2'd2: w_y = w_relu;
`endif
            2'd3: w_y = (w_relu > w_cmax) ? w_cmax : w_relu;
            default: w_y = w_x;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sel      <= 1'b0;
            r_w        <= 1'b0;
            r_addr_oe  <= 1'b0;
            r_data_oe  <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_mode     <= '0;
            r_clamp    <= '0;
            r_in_base  <= '0;
            r_out_base <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_RD;
                        r_idx      <= '0;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_sel      <= 1'b1;
                        r_w        <= 1'b0;
                        r_addr_oe  <= 1'b1;
                        r_addr     <= input_addr;
                        r_mode     <= mode;
                        r_clamp    <= clamp_max;
                        r_in_base  <= input_addr;
                        r_out_base <= output_addr;
                    end
                end
                S_RD: begin
                    r_state <= S_CAP;
                end
                S_CAP: begin
                    r_state   <= S_WR;
                    r_w       <= 1'b1;
                    r_data_oe <= 1'b1;
                    r_addr    <= r_out_base + ADDR_WIDTH'(r_idx);
                    r_wdata   <= DATABUS_WIDTH'(w_y);
                end
                S_WR: begin
                    r_w       <= 1'b0;
                    r_data_oe <= 1'b0;
                    if (w_last) begin
                        r_state   <= S_DONE;
                        r_sel     <= 1'b0;
                        r_addr_oe <= 1'b0;
                    end else begin
                        r_state <= S_RD;
                        r_idx   <= w_idx_nxt;
                        r_addr  <= r_in_base + ADDR_WIDTH'(w_idx_nxt);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_idx   <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign mem_sel     = r_sel;
    assign mem_w       = r_w;
    assign address_bus = r_addr_oe ? r_addr : 'z;
    assign data_bus    = r_data_oe ? r_wdata : 'z;

endmodule

// File: tb/tb_act_with_mem.sv
// Table-driven bench for act_with_mem with memory models and a write scoreboard.
// Honours ACT_LEAKY_EN in its expected mode-2 results.
module tb_act_with_mem;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              start2;
    logic [1:0]        mode;
    logic [3:0]        shift;
    logic signed [7:0] clamp;
    logic [7:0]        in_a;
    logic [7:0]        out_a;

    logic              busy, done, mem_sel, mem_w;
    wire  [7:0]        address_bus;
    wire  [31:0]       data_bus;
    logic              busy2, done2, mem_sel2, mem_w2;
    wire  [7:0]        address_bus2;
    wire  [31:0]       data_bus2;

    logic [7:0] mem  [256];
    logic [7:0] mem2 [256];

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t q[$];
    wr_t q2[$];
    wr_t w1, w2;

    typedef struct {
        logic [1:0]        mode;
        logic [3:0]        shift;
        logic signed [7:0] clamp;
        logic [7:0]        out_a;
        bit                pulse;
        logic [5:0][7:0]   exp;
    } vec_t;

    vec_t tbl [8];
    logic signed [7:0] vin [6];
    logic signed [7:0] vin2 [12];

    always #5 clk = ~clk;

    act_with_mem u_dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .leak_shift(shift), .clamp_max(clamp),
        .input_addr(in_a), .output_addr(out_a),
        .busy(busy), .done(done), .mem_sel(mem_sel), .mem_w(mem_w),
        .address_bus(address_bus), .data_bus(data_bus)
    );

    act_with_mem #(.CHANNELS(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .mode(mode),
        .leak_shift(shift), .clamp_max(clamp),
        .input_addr(in_a), .output_addr(out_a),
        .busy(busy2), .done(done2), .mem_sel(mem_sel2), .mem_w(mem_w2),
        .address_bus(address_bus2), .data_bus(data_bus2)
    );

    assign data_bus = (mem_sel && !mem_w) ?
        {{24{mem[address_bus][7]}}, mem[address_bus]} : 'z;
    assign data_bus2 = (mem_sel2 && !mem_w2) ?
        {{24{mem2[address_bus2][7]}}, mem2[address_bus2]} : 'z;

    always @(posedge clk) begin
        if (mem_sel && mem_w)
            mem[address_bus] <= data_bus[7:0];
        if (mem_sel2 && mem_w2)
            mem2[address_bus2] <= data_bus2[7:0];
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && mem_sel && mem_w) begin
            if (q.size() == 0) begin
                check("wr_unexpected", 32'd1, 32'd0);
            end else begin
                w1 = q.pop_front();
                check("wr_addr", {24'd0, address_bus}, {24'd0, w1.a});
                check("wr_data", data_bus, w1.d);
            end
        end
        if (rst && mem_sel2 && mem_w2) begin
            if (q2.size() == 0) begin
                check("wr2_unexpected", 32'd1, 32'd0);
            end else begin
                w2 = q2.pop_front();
                check("wr2_addr", {24'd0, address_bus2}, {24'd0, w2.a});
                check("wr2_data", data_bus2, w2.d);
            end
        end
    end

    task automatic setv(input int i, input logic [1:0] m, input logic [3:0] s,
                        input logic signed [7:0] c, input logic [7:0] o,
                        input bit p, input logic signed [7:0] e0,
                        input logic signed [7:0] e1, input logic signed [7:0] e2,
                        input logic signed [7:0] e3, input logic signed [7:0] e4,
                        input logic signed [7:0] e5);
        tbl[i].mode  = m;
        tbl[i].shift = s;
        tbl[i].clamp = c;
        tbl[i].out_a = o;
        tbl[i].pulse = p;
        tbl[i].exp   = {e5, e4, e3, e2, e1, e0};
    endtask

    task automatic load_and_arm(input int v);
        for (int j = 0; j < 6; j++)
            mem[j] = vin[j];
        mode  = tbl[v].mode;
        shift = tbl[v].shift;
        clamp = tbl[v].clamp;
        in_a  = 8'd0;
        out_a = tbl[v].out_a;
        for (int j = 0; j < 6; j++)
            q.push_back({8'(tbl[v].out_a + 8'(j)),
                         {{24{tbl[v].exp[j][7]}}, tbl[v].exp[j]}});
    endtask

    task automatic accept_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode  = ~mode;
        shift = 4'd3;
        clamp = 8'sd1;
        in_a  = 8'd77;
        out_a = 8'd200;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("done_cleared", {31'd0, done}, 32'd0);
    endtask

    task automatic run(input int v);
        int  cnt;
        bit  busy_ok;
        cnt     = 0;
        busy_ok = 1'b1;
        load_and_arm(v);
        accept_start();
        while (!done && cnt < 200) begin
            @(posedge clk);
            #1;
            cnt++;
            if (!done && !busy)
                busy_ok = 1'b0;
            if (tbl[v].pulse)
                start = (cnt == 4);
        end
        start = 1'b0;
        check($sformatf("done_latency_v%0d", v), cnt, 32'd19);
        check("busy_held", {31'd0, busy_ok}, 32'd1);
        check("busy_low_at_done", {31'd0, busy}, 32'd0);
        check("queue_drained", q.size(), 32'd0);
        for (int j = 0; j < 6; j++)
            check($sformatf("mem_v%0d_%0d", v, j),
                  {24'd0, mem[8'(tbl[v].out_a + 8'(j))]},
                  {24'd0, tbl[v].exp[j]});
        repeat (3) @(posedge clk);
        #1;
        check("done_sticky", {31'd0, done}, 32'd1);
        check("idle_after_done", {31'd0, busy}, 32'd0);
        q.delete();
    endtask

    initial begin
        int cnt;
        rst    = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        mode   = '0;
        shift  = '0;
        clamp  = '0;
        in_a   = '0;
        out_a  = '0;
        for (int a = 0; a < 256; a++) begin
            mem[a]  = 8'h00;
            mem2[a] = 8'h00;
        end
        vin  = '{-8'sd3, -8'sd1, 8'sd0, 8'sd5, 8'sd127, -8'sd128};
        vin2 = '{-8'sd5, 8'sd10, -8'sd20, 8'sd30, -8'sd40, 8'sd50,
                 -8'sd60, 8'sd70, -8'sd80, 8'sd90, -8'sd100, 8'sd110};

        setv(0, 2'd1, 4'd0, 8'sd0, 8'd100, 0, 0, 0, 0, 5, 127, 0);
`ifdef ACT_LEAKY_EN
        setv(1, 2'd2, 4'd1, 8'sd0, 8'd100, 0, -2, -1, 0, 5, 127, -64);
        setv(5, 2'd2, 4'd9, 8'sd0, 8'd110, 0, -1, -1, 0, 5, 127, -1);
        setv(7, 2'd2, 4'd0, 8'sd0, 8'd100, 0, -3, -1, 0, 5, 127, -128);
`else
        setv(1, 2'd2, 4'd1, 8'sd0, 8'd100, 0, 0, 0, 0, 5, 127, 0);
        setv(5, 2'd2, 4'd9, 8'sd0, 8'd110, 0, 0, 0, 0, 5, 127, 0);
        setv(7, 2'd2, 4'd0, 8'sd0, 8'd100, 0, 0, 0, 0, 5, 127, 0);
`endif
        setv(2, 2'd3, 4'd0, 8'sd6, 8'd100, 0, 0, 0, 0, 5, 6, 0);
        setv(3, 2'd3, 4'd0, -8'sd4, 8'd100, 0, 0, 0, 0, 0, 0, 0);
        setv(4, 2'd0, 4'd0, 8'sd0, 8'd0, 1, -3, -1, 0, 5, 127, -128);
        setv(6, 2'd3, 4'd0, 8'sd127, 8'd100, 0, 0, 0, 0, 5, 127, 0);

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sel", {31'd0, mem_sel}, 32'd0);
        check("rst_w", {31'd0, mem_w}, 32'd0);
        check("rst_busy2", {31'd0, busy2}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int v = 0; v < 8; v++)
            run(v);

        // abort during element 3's write phase
        load_and_arm(0);
        cnt = 0;
        accept_start();
        while (cnt < 11) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("abort_in_wr", {31'd0, mem_w}, 32'd1);
        rst = 1'b0;
        #1;
        check("abort_sel", {31'd0, mem_sel}, 32'd0);
        check("abort_w", {31'd0, mem_w}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_pending", q.size(), 32'd3);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("abort_done_hold", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int a = 100; a < 106; a++)
            mem[a] = 8'h55;
        run(2);

        // 12-element run whose reads wrap past address 255
        for (int j = 0; j < 12; j++) begin
            mem2[8'(8'd250 + 8'(j))] = vin2[j];
            q2.push_back({8'(8'd120 + 8'(j)),
                          vin2[j][7] ? 32'd0 : {24'd0, vin2[j]}});
        end
        mode  = 2'd1;
        in_a  = 8'd250;
        out_a = 8'd120;
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        check("wrap_busy", {31'd0, busy2}, 32'd1);
        cnt = 0;
        while (!done2 && cnt < 300) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("wrap_latency", cnt, 32'd37);
        check("wrap_queue", q2.size(), 32'd0);
        for (int j = 0; j < 12; j++)
            check($sformatf("wrap_mem_%0d", j), {24'd0, mem2[120 + j]},
                  vin2[j][7] ? 32'd0 : {24'd0, vin2[j]});
        check("wrap_src_kept", {24'd0, mem2[0]}, {24'd0, vin2[6]});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
